// File: rtl/nn_pkg.sv
// Shared neural-network datapath defaults and the ReLU/saturation helper
// used by every layer's output stage.
package nn_pkg;

   localparam int ACC_W      = 20;
   localparam int OUT_W      = 8;
   localparam int FRAC_SHIFT = 4;

   // Result of relu_sat: activation in the low out_w bits of val, clip set when clamped high.
   typedef struct packed {
      logic        clip;
      logic [31:0] val;
   } relu_t;

   // Arithmetic shift, clamp negatives to zero, clamp above 2^out_w-1. Supports out_w <= 31.
   function automatic relu_t relu_sat(input logic signed [63:0] sum,
                                      input int unsigned        shift,
                                      input int unsigned        out_w);
      logic signed [63:0] sh;
      logic signed [63:0] max_v;
      relu_t              r;
      sh     = sum >>> shift;
      max_v  = (64'sd1 <<< out_w) - 64'sd1;
      r.clip = 1'b0;
      r.val  = 32'd0;
      if (sh < 64'sd0) begin
         r.val = 32'd0;
      end else if (sh > max_v) begin
         r.clip = 1'b1;
         r.val  = max_v[31:0];
      end else begin
         r.val  = sh[31:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/nn_fifo.sv
// Small power-of-two FIFO with explicit occupancy count and a registered head,
// so the consumer sees a flop output rather than a memory read path.
module nn_fifo
   import nn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       ack,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       push_ok
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] rd_inc_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic [W-1:0]  head_r;
   logic [W-1:0]  head_nxt_s;
   logic          valid_r;
   logic          pop_s;
   logic          push_ok_s;

   assign pop_s     = valid_r & ack;
   assign push_ok_s = push & ((count_r < CW'(DEPTH)) | pop_s);
   assign rd_inc_s  = rd_ptr_r + AW'(1);

   // Next occupancy and next head; an entry pushed into an empty FIFO becomes head one edge later.
   always_comb begin
      count_nxt_s = count_r;
      head_nxt_s  = head_r;
      if (push_ok_s & ~pop_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (pop_s & ~push_ok_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
      if (pop_s) begin
         if (count_r > CW'(1)) begin
            head_nxt_s = mem_r[rd_inc_s];
         end else if (push_ok_s) begin
            head_nxt_s = din;
         end else begin
            head_nxt_s = {W{1'b0}};
         end
      end else if (push_ok_s & (count_r == CW'(0))) begin
         head_nxt_s = din;
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Storage, pointers, occupancy and registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         head_r   <= {W{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_inc_s;
         end
         count_r <= count_nxt_s;
         head_r  <= head_nxt_s;
         valid_r <= (count_nxt_s != CW'(0));
      end
   end

   assign dout    = head_r;
   assign valid   = valid_r;
   assign count   = count_r;
   assign push_ok = push_ok_s;

endmodule

// File: rtl/neuron_output_stage.sv
// Neuron output stage: capture accumulator+bias, rescale with ReLU/saturation,
// and queue activations for the next layer behind a valid/ack FIFO.
module neuron_output_stage
   import nn_pkg::*;
#(
   parameter int ACC_W      = nn_pkg::ACC_W,
   parameter int OUT_W      = nn_pkg::OUT_W,
   parameter int FRAC_SHIFT = nn_pkg::FRAC_SHIFT,
   parameter int DEPTH      = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done_in,
   input  logic [ACC_W-1:0]           acc_in,
   input  logic [ACC_W-1:0]           bias_in,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ack,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sat_flag,
   output logic                       drop_err
);

   localparam int CW = $clog2(DEPTH+1);

   logic signed [ACC_W:0] sum_r;
   logic                  s1_v_r;
   relu_t                 relu_s;
   logic [OUT_W-1:0]      act_s;
   logic                  push_ok_s;
   logic                  sat_flag_r;
   logic                  drop_err_r;
   logic                  unused_s;

   // S1: sum is one bit wider than the operands so it can never overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_r  <= {(ACC_W+1){1'b0}};
         s1_v_r <= 1'b0;
      end else begin
         s1_v_r <= done_in;
         if (done_in) begin
            sum_r <= {acc_in[ACC_W-1], acc_in} + {bias_in[ACC_W-1], bias_in};
         end
      end
   end

   assign relu_s   = relu_sat(64'(sum_r), FRAC_SHIFT, OUT_W);
   assign act_s    = relu_s.val[OUT_W-1:0];
   assign unused_s = ^relu_s.val[31:OUT_W];

   nn_fifo #(
      .DEPTH (DEPTH),
      .W     (OUT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (s1_v_r),
      .ack     (out_ack),
      .din     (act_s),
      .dout    (out_data),
      .valid   (out_valid),
      .count   (count),
      .push_ok (push_ok_s)
   );

   // Clip pulse for accepted pushes only; drop error stays set until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag_r <= 1'b0;
         drop_err_r <= 1'b0;
      end else begin
         sat_flag_r <= push_ok_s & relu_s.clip;
         drop_err_r <= drop_err_r | (s1_v_r & ~push_ok_s);
      end
   end

   assign sat_flag = sat_flag_r;
   assign drop_err = drop_err_r;
   assign full     = (count == CW'(DEPTH)) | ((count == CW'(DEPTH-1)) & s1_v_r);

endmodule

// File: tb/tb_neuron_output_stage.sv
// Directed bench for neuron_output_stage: ReLU/saturation vectors, overflow,
// push/pop at full across pointer wrap, and reset mid-stream.
module tb_neuron_output_stage;

   localparam int ACC_W = 20;
   localparam int OUT_W = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             done_in = 1'b0;
   logic [ACC_W-1:0] acc_in = '0;
   logic [ACC_W-1:0] bias_in = '0;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ack = 1'b0;
   logic             full;
   logic [CW-1:0]    count;
   logic             sat_flag;
   logic             drop_err;

   int tests_run    = 0;
   int tests_failed = 0;

   neuron_output_stage #(
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .FRAC_SHIFT (4),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .done_in   (done_in),
      .acc_in    (acc_in),
      .bias_in   (bias_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .full      (full),
      .count     (count),
      .sat_flag  (sat_flag),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d, input int acc, input int bias);
      done_in = d;
      acc_in  = ACC_W'(acc);
      bias_in = ACC_W'(bias);
   endtask

   int vec_acc  [9] = '{100, -500, 100000, 4095, 4096, -1, 15, -100, 524287};
   int vec_bias [9] = '{28,   10,  0,      0,    0,    0,  0,  120,  524287};
   int vec_exp  [9] = '{8,    0,   255,    255,  255,  0,  0,  1,    255};
   int vec_sat  [9] = '{0,    0,   1,      0,    1,    0,  0,  0,    1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset, with a done_in held coincident that must be ignored
      rst = 1'b1;
      drive(1'b1, 100000, 0);
      tick();
      tick();
      drive(1'b0, 0, 0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_sat", 32'(sat_flag), 32'd0);
      check_eq("rst_drop", 32'(drop_err), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick();
      tick();
      check_eq("rst_done_ignored", 32'(out_valid), 32'd0);

      // Single results through the ReLU path
      for (int v = 0; v < 9; v++) begin
         drive(1'b1, vec_acc[v], vec_bias[v]);
         tick();
         drive(1'b0, 0, 0);
         check_eq($sformatf("v%0d_valid_t1", v), 32'(out_valid), 32'd0);
         tick();
         check_eq($sformatf("v%0d_valid_t2", v), 32'(out_valid), 32'd1);
         check_eq($sformatf("v%0d_data", v), 32'(out_data), 32'(vec_exp[v]));
         check_eq($sformatf("v%0d_sat", v), 32'(sat_flag), 32'(vec_sat[v]));
         check_eq($sformatf("v%0d_count", v), 32'(count), 32'd1);
         out_ack = 1'b1;
         tick();
         out_ack = 1'b0;
         check_eq($sformatf("v%0d_sat_clear", v), 32'(sat_flag), 32'd0);
         check_eq($sformatf("v%0d_empty", v), 32'(out_valid), 32'd0);
         check_eq($sformatf("v%0d_count0", v), 32'(count), 32'd0);
      end
      check_eq("ack_idle_ignored", 32'(count), 32'd0);

      // Overflow: six back-to-back results, no ack
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 16 * (k + 1), 0);
         check_eq($sformatf("ovf_full_c%0d", k), 32'(full), (k >= 4) ? 32'd1 : 32'd0);
         if (k == 4) check_eq("ovf_count_c4", 32'(count), 32'd3);
         tick();
      end
      drive(1'b0, 0, 0);
      check_eq("ovf_count", 32'(count), 32'd4);
      check_eq("ovf_drop", 32'(drop_err), 32'd1);
      tick();
      check_eq("ovf_full_hold", 32'(full), 32'd1);
      out_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(i + 1));
         tick();
      end
      out_ack = 1'b0;
      check_eq("ovf_drained", 32'(count), 32'd0);
      check_eq("ovf_drained_valid", 32'(out_valid), 32'd0);
      check_eq("ovf_drop_sticky", 32'(drop_err), 32'd1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst2_drop", 32'(drop_err), 32'd0);

      // Push and pop together at count == DEPTH, write pointer wraps
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 160 * (k + 1), 0);
         tick();
      end
      drive(1'b0, 0, 0);
      check_eq("pp_count_before", 32'(count), 32'd4);
      out_ack = 1'b1;
      tick();
      check_eq("pp_count_after", 32'(count), 32'd4);
      check_eq("pp_drop", 32'(drop_err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("pp_order%0d", i), 32'(out_data), 32'(20 + 10 * i));
         tick();
      end
      out_ack = 1'b0;
      check_eq("pp_empty", 32'(count), 32'd0);

      // Reset with three entries queued and S1 occupied
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16 * (k + 1), 0);
         tick();
      end
      check_eq("mid_count3", 32'(count), 32'd3);
      check_eq("mid_full_s1", 32'(full), 32'd1);
      rst = 1'b1;
      drive(1'b1, 1600, 0);
      tick();
      rst = 1'b0;
      drive(1'b0, 0, 0);
      check_eq("mid_count", 32'(count), 32'd0);
      check_eq("mid_valid", 32'(out_valid), 32'd0);
      check_eq("mid_drop", 32'(drop_err), 32'd0);
      check_eq("mid_full", 32'(full), 32'd0);
      check_eq("mid_data", 32'(out_data), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("mid_nostale%0d", i), 32'(out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
